// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-manager external-memory AHB arbiter.
package ahb_arb_pkg;

  // Hold-slot address field width; the top casts its PA_BITS address into it.
  localparam int unsigned ARB_PA_BITS = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  typedef struct packed {
    logic [ARB_PA_BITS-1:0] haddr;
    logic                   hwrite;
    logic [2:0]             hsize;
    logic [2:0]             hburst;
    logic [1:0]             htrans;
  } ahb_req_t;

endpackage

// File: rtl/ahb_req_capture.sv
// One-entry address-phase hold slot; capture has priority over clear.
module ahb_req_capture
  import ahb_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     capture,
  input  logic     clear,
  input  ahb_req_t req_in,
  output logic     valid,
  output ahb_req_t req
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      req   <= req_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_extmem_arbiter.sv
// Two-manager AHB-Lite arbiter for the external-memory subordinate, burst-preserving, M0 priority.
// Optional starvation guard for M1 enabled by defining EXTMEM_ARB_STARVE_EN.
module ahb_extmem_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned PA_BITS = 32,
  parameter int unsigned AHBW    = 32
`ifdef EXTMEM_ARB_STARVE_EN
  ,
  parameter int unsigned STARVE_LIMIT = 8
`endif
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [PA_BITS-1:0]  M0_HADDR,
  input  logic [1:0]          M0_HTRANS,
  input  logic                M0_HWRITE,
  input  logic [2:0]          M0_HSIZE,
  input  logic [2:0]          M0_HBURST,
  input  logic [AHBW-1:0]     M0_HWDATA,
  input  logic [AHBW/8-1:0]   M0_HWSTRB,
  output logic [AHBW-1:0]     M0_HRDATA,
  output logic                M0_HREADY,
  output logic                M0_HRESP,
  input  logic [PA_BITS-1:0]  M1_HADDR,
  input  logic [1:0]          M1_HTRANS,
  input  logic                M1_HWRITE,
  input  logic [2:0]          M1_HSIZE,
  input  logic [2:0]          M1_HBURST,
  input  logic [AHBW-1:0]     M1_HWDATA,
  input  logic [AHBW/8-1:0]   M1_HWSTRB,
  output logic [AHBW-1:0]     M1_HRDATA,
  output logic                M1_HREADY,
  output logic                M1_HRESP,
  output logic [PA_BITS-1:0]  S_HADDR,
  output logic [1:0]          S_HTRANS,
  output logic                S_HWRITE,
  output logic [2:0]          S_HSIZE,
  output logic [2:0]          S_HBURST,
  output logic [AHBW-1:0]     S_HWDATA,
  output logic [AHBW/8-1:0]   S_HWSTRB,
  input  logic [AHBW-1:0]     S_HRDATA,
  input  logic                S_HREADYOUT,
  input  logic                S_HRESP,
  output logic                S_HREADY,
  output logic                GrantM1
);

  owner_e   state, gnt_c;
  ahb_req_t live0, live1, slot0, slot1, sel;
  logic     slot0_valid, slot1_valid;
  logic     d_valid, d_owner;
  logic     pend0, pend1, locked_c;
  logic     cap0, cap1, clr0, clr1;
  logic     hready0_c, hready1_c;
  logic [1:0] eff0, eff1;
`ifdef EXTMEM_ARB_STARVE_EN
  logic     starve_hit_c;
`endif

  assign live0 = '{haddr: ARB_PA_BITS'(M0_HADDR), hwrite: M0_HWRITE, hsize: M0_HSIZE,
                   hburst: M0_HBURST, htrans: M0_HTRANS};
  assign live1 = '{haddr: ARB_PA_BITS'(M1_HADDR), hwrite: M1_HWRITE, hsize: M1_HSIZE,
                   hburst: M1_HBURST, htrans: M1_HTRANS};

  assign eff0  = slot0_valid ? slot0.htrans : M0_HTRANS;
  assign eff1  = slot1_valid ? slot1.htrans : M1_HTRANS;
  assign pend0 = M0_HTRANS[1] | slot0_valid;
  assign pend1 = M1_HTRANS[1] | slot1_valid;

  // Address-phase owner: SEQ/BUSY lock it, wait states hold it, otherwise re-arbitrate.
  always_comb begin
    gnt_c    = OWN_IDLE;
    locked_c = 1'b0;
    if (HRESETn) begin
      locked_c = (state == OWN_M0 && (eff0 == HTRANS_SEQ || eff0 == HTRANS_BUSY)) ||
                 (state == OWN_M1 && (eff1 == HTRANS_SEQ || eff1 == HTRANS_BUSY));
      if (locked_c || !S_HREADYOUT) begin
        gnt_c = state;
`ifdef EXTMEM_ARB_STARVE_EN
      end else if (starve_hit_c && pend1) begin
        gnt_c = OWN_M1;
`endif
      end else if (pend0) begin
        gnt_c = OWN_M0;
      end else if (pend1) begin
        gnt_c = OWN_M1;
      end
    end
  end

  always_comb begin
    sel = '{haddr: '0, hwrite: 1'b0, hsize: '0, hburst: '0, htrans: HTRANS_IDLE};
    if (gnt_c == OWN_M0) begin
      sel = slot0_valid ? slot0 : live0;
    end else if (gnt_c == OWN_M1) begin
      sel = slot1_valid ? slot1 : live1;
    end
  end

  // A deferred manager stalls until its replay completes; the data-phase owner follows the subordinate.
  always_comb begin
    hready0_c = 1'b1;
    hready1_c = 1'b1;
    if (slot0_valid) begin
      hready0_c = 1'b0;
    end else if ((d_valid && !d_owner) || gnt_c == OWN_M0) begin
      hready0_c = S_HREADYOUT;
    end
    if (slot1_valid) begin
      hready1_c = 1'b0;
    end else if ((d_valid && d_owner) || gnt_c == OWN_M1) begin
      hready1_c = S_HREADYOUT;
    end
  end

  assign cap0 = (M0_HTRANS == HTRANS_NONSEQ) && (gnt_c != OWN_M0) && !slot0_valid && hready0_c;
  assign cap1 = (M1_HTRANS == HTRANS_NONSEQ) && (gnt_c != OWN_M1) && !slot1_valid && hready1_c;
  assign clr0 = slot0_valid && (gnt_c == OWN_M0) && S_HREADYOUT;
  assign clr1 = slot1_valid && (gnt_c == OWN_M1) && S_HREADYOUT;

  ahb_req_capture u_slot0 (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .capture (cap0),
    .clear   (clr0),
    .req_in  (live0),
    .valid   (slot0_valid),
    .req     (slot0)
  );

  ahb_req_capture u_slot1 (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .capture (cap1),
    .clear   (clr1),
    .req_in  (live1),
    .valid   (slot1_valid),
    .req     (slot1)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= OWN_IDLE;
      d_valid <= 1'b0;
      d_owner <= 1'b0;
    end else begin
      state <= gnt_c;
      if (S_HREADYOUT) begin
        d_valid <= sel.htrans[1];
        d_owner <= (gnt_c == OWN_M1);
      end
    end
  end

`ifdef EXTMEM_ARB_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit_c = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Counts M0 wins at arbitration points while M1 waits; saturates at the limit.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      starve_cnt <= '0;
    end else if (S_HREADYOUT && !locked_c) begin
      if (gnt_c == OWN_M1) begin
        starve_cnt <= '0;
      end else if (gnt_c == OWN_M0 && pend1 && !starve_hit_c) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`endif

  assign S_HADDR   = PA_BITS'(sel.haddr);
  assign S_HTRANS  = sel.htrans;
  assign S_HWRITE  = sel.hwrite;
  assign S_HSIZE   = sel.hsize;
  assign S_HBURST  = sel.hburst;
  assign S_HWDATA  = !d_valid ? '0 : (d_owner ? M1_HWDATA : M0_HWDATA);
  assign S_HWSTRB  = !d_valid ? '0 : (d_owner ? M1_HWSTRB : M0_HWSTRB);
  assign S_HREADY  = S_HREADYOUT;
  assign GrantM1   = (gnt_c == OWN_M1);

  assign M0_HRDATA = (d_valid && !d_owner) ? S_HRDATA : '0;
  assign M1_HRDATA = (d_valid &&  d_owner) ? S_HRDATA : '0;
  assign M0_HRESP  = d_valid && !d_owner && S_HRESP;
  assign M1_HRESP  = d_valid &&  d_owner && S_HRESP;
  assign M0_HREADY = hready0_c;
  assign M1_HREADY = hready1_c;

endmodule

// File: tb/tb_ahb_extmem_arbiter.sv
// Directed cycle-by-cycle bench for ahb_extmem_arbiter; the subordinate is driven by hand.
module tb_ahb_extmem_arbiter;

  logic        HCLK, HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HWSTRB, M1_HWSTRB;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE, S_HREADYOUT, S_HRESP, S_HREADY, GrantM1;
  logic [2:0]  S_HSIZE, S_HBURST;
  logic [3:0]  S_HWSTRB;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef EXTMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
  ahb_extmem_arbiter #(.PA_BITS(32), .AHBW(32), .STARVE_LIMIT(4)) dut (
`else
  localparam bit STARVE = 1'b0;
  ahb_extmem_arbiter #(.PA_BITS(32), .AHBW(32)) dut (
`endif
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HWDATA(M0_HWDATA), .M0_HWSTRB(M0_HWSTRB),
    .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HWDATA(M1_HWDATA), .M1_HWSTRB(M1_HWSTRB),
    .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HBURST(S_HBURST), .S_HWDATA(S_HWDATA), .S_HWSTRB(S_HWSTRB), .S_HRDATA(S_HRDATA),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HREADY(S_HREADY), .GrantM1(GrantM1)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive just after the edge, then let combinational outputs settle before checking.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] b);
    M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = w; M0_HBURST = b; M0_HSIZE = 3'b010;
  endtask

  task automatic m1(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] b);
    M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = w; M1_HBURST = b; M1_HSIZE = 3'b010;
  endtask

  task automatic sub(input logic rdy, input logic resp, input logic [31:0] rd);
    S_HREADYOUT = rdy; S_HRESP = resp; S_HRDATA = rd;
  endtask

  initial begin
    HRESETn = 1'b0;
    m0(2'b00, 32'h0, 1'b0, 3'b000);
    m1(2'b00, 32'h0, 1'b0, 3'b000);
    M0_HWDATA = '0; M1_HWDATA = '0; M0_HWSTRB = '0; M1_HWSTRB = '0;
    sub(1'b1, 1'b0, 32'h0);
    tick(); tick(); #1;

    // Reset state
    check("rst_htrans", S_HTRANS, 2'b00);
    check("rst_haddr", S_HADDR, 32'h0);
    check("rst_m0_hready", M0_HREADY, 1'b1);
    check("rst_m1_hready", M1_HREADY, 1'b1);
    check("rst_grant", GrantM1, 1'b0);
    check("rst_m0_hresp", M0_HRESP, 1'b0);
    tick(); HRESETn = 1'b1;
    tick();

    // M0 single read, live path, zero added latency
    tick(); m0(2'b10, 32'h2000_0040, 1'b0, 3'b000); #1;
    check("t1_haddr", S_HADDR, 32'h2000_0040);
    check("t1_htrans", S_HTRANS, 2'b10);
    check("t1_m0_hready", M0_HREADY, 1'b1);
    tick(); m0(2'b00, 32'h0, 1'b0, 3'b000); sub(1'b1, 1'b0, 32'hDEAD_BEEF); #1;
    check("t1_m0_hrdata", M0_HRDATA, 32'hDEAD_BEEF);
    check("t1_m1_hrdata", M1_HRDATA, 32'h0);
    check("t1_m0_hready_d", M0_HREADY, 1'b1);
    tick(); sub(1'b1, 1'b0, 32'h0);

    // Simultaneous NONSEQ: M0 first, M1 captured and replayed next cycle
    tick(); m0(2'b10, 32'h2000_0000, 1'b0, 3'b000); m1(2'b10, 32'h2000_1000, 1'b0, 3'b000); #1;
    check("t2_haddr_m0", S_HADDR, 32'h2000_0000);
    check("t2_m1_hready_cap", M1_HREADY, 1'b1);
    check("t2_grant0", GrantM1, 1'b0);
    tick(); m0(2'b00, 32'h0, 1'b0, 3'b000); m1(2'b00, 32'h0, 1'b0, 3'b000);
    sub(1'b1, 1'b0, 32'h1111_0000); #1;
    check("t2_haddr_m1", S_HADDR, 32'h2000_1000);
    check("t2_htrans_m1", S_HTRANS, 2'b10);
    check("t2_grant1", GrantM1, 1'b1);
    check("t2_m1_hready_wait", M1_HREADY, 1'b0);
    check("t2_m0_hrdata", M0_HRDATA, 32'h1111_0000);
    tick(); sub(1'b0, 1'b0, 32'h0); #1;
    check("t2_m1_hready_ws", M1_HREADY, 1'b0);
    check("t2_m0_hready_ws", M0_HREADY, 1'b1);
    check("t2_htrans_idle", S_HTRANS, 2'b00);
    tick(); sub(1'b1, 1'b0, 32'h2222_1111); #1;
    check("t2_m1_hready_d", M1_HREADY, 1'b1);
    check("t2_m1_hrdata", M1_HRDATA, 32'h2222_1111);
    check("t2_m0_hrdata_0", M0_HRDATA, 32'h0);
    tick(); sub(1'b1, 1'b0, 32'h0);

    // M1 INCR4 locks the bus; M0 NONSEQ at beat 2 follows the burst
    tick(); m1(2'b10, 32'h2000_2000, 1'b0, 3'b011); #1;
    check("t3_b1", S_HADDR, 32'h2000_2000);
    check("t3_grant", GrantM1, 1'b1);
    check("t3_hburst", S_HBURST, 3'b011);
    tick(); m1(2'b11, 32'h2000_2004, 1'b0, 3'b011); m0(2'b10, 32'h2000_3000, 1'b0, 3'b000);
    sub(1'b1, 1'b0, 32'h0000_00B1); #1;
    check("t3_b2", S_HADDR, 32'h2000_2004);
    check("t3_b2_htrans", S_HTRANS, 2'b11);
    check("t3_m0_hready_cap", M0_HREADY, 1'b1);
    tick(); m1(2'b11, 32'h2000_2008, 1'b0, 3'b011); m0(2'b00, 32'h0, 1'b0, 3'b000);
    sub(1'b1, 1'b0, 32'h0000_00B2); #1;
    check("t3_b3", S_HADDR, 32'h2000_2008);
    check("t3_m0_hready_held", M0_HREADY, 1'b0);
    tick(); m1(2'b11, 32'h2000_200C, 1'b0, 3'b011); sub(1'b1, 1'b0, 32'h0000_00B3); #1;
    check("t3_b4", S_HADDR, 32'h2000_200C);
    check("t3_b4_grant", GrantM1, 1'b1);
    tick(); m1(2'b00, 32'h0, 1'b0, 3'b000); sub(1'b1, 1'b0, 32'h0000_00B4); #1;
    check("t3_m0_after", S_HADDR, 32'h2000_3000);
    check("t3_m0_grant", GrantM1, 1'b0);
    check("t3_m1_last_data", M1_HRDATA, 32'h0000_00B4);
    check("t3_m0_hrdata_0", M0_HRDATA, 32'h0);
    tick(); sub(1'b1, 1'b0, 32'h3333_3333); #1;
    check("t3_m0_hrdata", M0_HRDATA, 32'h3333_3333);
    check("t3_m0_hready", M0_HREADY, 1'b1);
    tick(); sub(1'b1, 1'b0, 32'h0);

    // Two-cycle error on M1 write goes only to M1; pending M0 completes after
    tick(); m1(2'b10, 32'h2000_4000, 1'b1, 3'b000); #1;
    check("t4_grant", GrantM1, 1'b1);
    check("t4_hwrite", S_HWRITE, 1'b1);
    tick(); m1(2'b00, 32'h0, 1'b0, 3'b000); M1_HWDATA = 32'hCAFE_F00D; M1_HWSTRB = 4'hF;
    m0(2'b10, 32'h2000_5000, 1'b0, 3'b000); sub(1'b0, 1'b1, 32'h0); #1;
    check("t4_hwdata", S_HWDATA, 32'hCAFE_F00D);
    check("t4_hwstrb", S_HWSTRB, 4'hF);
    check("t4_m1_hresp1", M1_HRESP, 1'b1);
    check("t4_m1_hready1", M1_HREADY, 1'b0);
    check("t4_m0_hresp1", M0_HRESP, 1'b0);
    check("t4_s_hready", S_HREADY, 1'b0);
    tick(); m0(2'b00, 32'h0, 1'b0, 3'b000); sub(1'b1, 1'b1, 32'h0); #1;
    check("t4_m1_hresp2", M1_HRESP, 1'b1);
    check("t4_m1_hready2", M1_HREADY, 1'b1);
    check("t4_m0_hresp2", M0_HRESP, 1'b0);
    check("t4_m0_replay", S_HADDR, 32'h2000_5000);
    check("t4_m0_hready_wait", M0_HREADY, 1'b0);
    tick(); M1_HWDATA = '0; M1_HWSTRB = '0; sub(1'b1, 1'b0, 32'h5555_5555); #1;
    check("t4_m0_hrdata", M0_HRDATA, 32'h5555_5555);
    check("t4_m0_hready_d", M0_HREADY, 1'b1);
    check("t4_m1_hresp_0", M1_HRESP, 1'b0);
    tick(); sub(1'b1, 1'b0, 32'h0);

    // Reset during M0 INCR8 beat 3 with an M1 request held in its slot
    tick(); m0(2'b10, 32'h2000_6000, 1'b0, 3'b101); #1;
    check("t5_b1", S_HADDR, 32'h2000_6000);
    check("t5_hsize", S_HSIZE, 3'b010);
    tick(); m0(2'b11, 32'h2000_6004, 1'b0, 3'b101); m1(2'b10, 32'h2000_7000, 1'b0, 3'b000); #1;
    check("t5_m1_cap", M1_HREADY, 1'b1);
    tick(); m0(2'b11, 32'h2000_6008, 1'b0, 3'b101); m1(2'b00, 32'h0, 1'b0, 3'b000); #1;
    check("t5_m1_held", M1_HREADY, 1'b0);
    HRESETn = 1'b0;
    tick(); HRESETn = 1'b1; m0(2'b00, 32'h0, 1'b0, 3'b000); sub(1'b1, 1'b0, 32'h9999_9999); #1;
    check("t5_htrans_idle", S_HTRANS, 2'b00);
    check("t5_m0_hready", M0_HREADY, 1'b1);
    check("t5_m1_hready", M1_HREADY, 1'b1);
    check("t5_m0_hrdata_0", M0_HRDATA, 32'h0);
    check("t5_grant", GrantM1, 1'b0);
    tick(); m1(2'b10, 32'h2000_8000, 1'b0, 3'b000); sub(1'b1, 1'b0, 32'h0); #1;
    check("t5_post_haddr", S_HADDR, 32'h2000_8000);
    check("t5_post_grant", GrantM1, 1'b1);
    tick(); m1(2'b00, 32'h0, 1'b0, 3'b000); sub(1'b1, 1'b0, 32'h8888_8888); #1;
    check("t5_post_hrdata", M1_HRDATA, 32'h8888_8888);
    tick(); sub(1'b1, 1'b0, 32'h0);

    // M0 back-to-back singles with M1 waiting: starvation guard vs strict priority
    for (int i = 0; i < 5; i++) begin
      tick();
      m0(2'b10, 32'h2000_9000 + 32'(4 * i), 1'b0, 3'b000);
      if (i == 0) m1(2'b10, 32'h2000_A000, 1'b0, 3'b000);
      else        m1(2'b00, 32'h0, 1'b0, 3'b000);
      #1;
      if (i < 4) begin
        check("t6_m0_win", S_HADDR, 32'h2000_9000 + 32'(4 * i));
        check("t6_grant0", GrantM1, 1'b0);
      end else begin
        check("t6_b5_grant", GrantM1, STARVE);
        check("t6_b5_haddr", S_HADDR, STARVE ? 32'h2000_A000 : 32'h2000_9010);
      end
    end
    tick(); m0(2'b00, 32'h0, 1'b0, 3'b000); #1;
    check("t6_b6_grant", GrantM1, !STARVE);
    check("t6_b6_haddr", S_HADDR, STARVE ? 32'h2000_9010 : 32'h2000_A000);
    tick(); #1;
    check("t6_drain_idle", S_HTRANS, 2'b00);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
